// File: rtl/mantissa_sub_normalizer_if.sv
// Handshake and data bundle for the effective-subtraction mantissa stage.
// The master side drives operands and accepts results; the slave side is the datapath.
interface mantissa_sub_normalizer_if #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic [EXP_W-1:0] exp_in;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-1:0] res_man;
    logic [EXP_W-1:0] res_exp;
    logic             res_sign;
    logic             res_zero;
    logic             underflow;

    modport master (
        output in_valid, a_man, b_man, exp_in, out_ready,
        input  in_ready, out_valid, res_man, res_exp, res_sign, res_zero, underflow
    );

    modport slave (
        input  in_valid, a_man, b_man, exp_in, out_ready,
        output in_ready, out_valid, res_man, res_exp, res_sign, res_zero, underflow
    );
endinterface

// File: rtl/mantissa_sub_normalizer.sv
// Effective-subtraction mantissa datapath: computes |a-b| with its sign, then
// renormalizes one bit per cycle, decrementing the exponent on each shift and
// stopping at exponent 0 with an underflow (denormal) flag.
module mantissa_sub_normalizer #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mantissa_sub_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [MAN_W-1:0] a_r;
    logic [MAN_W-1:0] b_r;
    logic [EXP_W-1:0] exp_r;
    logic [MAN_W-1:0] mag_r;
    logic             sign_r;
    logic             zero_r;
    logic             underflow_r;
    logic             out_valid_r;

    logic [MAN_W:0]   diff_s;
    logic             borrow_s;
    logic [MAN_W-1:0] mag_sub_s;
    logic             exp_low_s;

    // Subtraction at MAN_W+1 bits; the extra bit is the borrow that selects b-a.
    always_comb begin
        diff_s    = {1'b0, a_r} - {1'b0, b_r};
        borrow_s  = diff_s[MAN_W];
        mag_sub_s = borrow_s ? (b_r - a_r) : diff_s[MAN_W-1:0];
        // At exponent 1 the mantissa scale already equals the denormal scale.
        exp_low_s = (exp_r <= EXP_W'(1));
    end

    // Control FSM and datapath registers; all result outputs come from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            exp_r       <= '0;
            mag_r       <= '0;
            sign_r      <= 1'b0;
            zero_r      <= 1'b0;
            underflow_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r         <= bus.a_man;
                        b_r         <= bus.b_man;
                        exp_r       <= bus.exp_in;
                        sign_r      <= 1'b0;
                        zero_r      <= 1'b0;
                        underflow_r <= 1'b0;
                        state_r     <= SUB;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                SUB: begin
                    if (a_r == b_r) begin
                        mag_r       <= '0;
                        sign_r      <= 1'b0;
                        zero_r      <= 1'b1;
                        exp_r       <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        mag_r       <= mag_sub_s;
                        sign_r      <= borrow_s;
                        state_r     <= NORM;
                    end
                end
                NORM: begin
                    if (mag_r[MAN_W-1]) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else if (exp_low_s) begin
                        exp_r       <= '0;
                        underflow_r <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        mag_r       <= {mag_r[MAN_W-2:0], 1'b0};
                        exp_r       <= exp_r - EXP_W'(1);
                        state_r     <= NORM;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.res_man   = mag_r;
    assign bus.res_exp   = exp_r;
    assign bus.res_sign  = sign_r;
    assign bus.res_zero  = zero_r;
    assign bus.underflow = underflow_r;

endmodule

// File: doc/mantissa_sub_normalizer.md
Name: mantissa_sub_normalizer

Overview:
Sequential effective-subtraction datapath for the FPU add/sub path. It is the counterpart of the carry-lookahead mantissa adder.
- Takes two aligned 24-bit mantissas (hidden bit included) and a common exponent.
- Produces the magnitude difference and its sign.
- Renormalizes with a one-bit-per-cycle left shift, decrementing the exponent on each shift.
- Sits between the exponent-alignment stage and the rounding stage, with valid/ready handshakes on both sides.

Parameters:
MAN_W, 24, mantissa width including hidden bit
EXP_W, 8, biased exponent width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  block idle and can accept operands
a_man  input  MAN_W  minuend mantissa (aligned)
b_man  input  MAN_W  subtrahend mantissa (aligned)
exp_in  input  EXP_W  common biased exponent
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
res_man  output  MAN_W  normalized magnitude |a-b|
res_exp  output  EXP_W  adjusted exponent
res_sign  output  1  1 when b_man > a_man
res_zero  output  1  difference is exactly zero
underflow  output  1  normalization stopped at exponent 0 (denormal result)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On a rst edge:
  - State becomes IDLE.
  - out_valid, res_man, res_exp, res_sign, res_zero and underflow all become 0.
  - Internal registers are cleared.
- Reset asserted mid-operation discards the operation; no out_valid is produced for it.
- in_ready = (state==IDLE) and not rst. It is a combinational decode of state.

States: IDLE, SUB, NORM, DONE.

IDLE:
- If in_valid, capture a_man, b_man, exp_in on the edge (acceptance edge E0) and go to SUB.
- Otherwise stay in IDLE.

SUB (one cycle):
- diff = a - b computed at MAN_W+1 bits.
- On borrow: mag = b - a, sign = 1. Otherwise mag = a - b, sign = 0.
- a == b: mag = 0, sign = 0, zero = 1, exp = 0; go to DONE at edge E1.
- Otherwise go to NORM at E1.

NORM (evaluated each cycle):
- mag[MAN_W-1] == 1: go to DONE; no shift.
- Else if exp <= 1: set exp = 0, underflow = 1, go to DONE; no shift. The mantissa scale at exponent 1 equals the denormal scale.
- Else: mag <<= 1 with zero fill, exp -= 1, stay in NORM.
- Exponent never wraps below 0.
- Latency: with k shifts, DONE is entered at edge E(k+2); out_valid is high from that edge. Zero result: out_valid is high from E1.
- k ≤ MAN_W-1 by construction, since mag is nonzero.

DONE:
- out_valid = 1. res_* outputs are registered and stable while out_valid is high.
- When out_valid && out_ready on an edge: clear out_valid and go to IDLE.
- in_ready stays low throughout DONE.
- The earliest next acceptance is the edge after return to IDLE. Simultaneous completion and new acceptance do not occur.
- Backpressure: out_ready low holds DONE and all outputs indefinitely.
- res_zero and underflow are mutually exclusive. res_sign = 0 whenever res_zero = 1.
- exp_in = 0 with MSB of mag clear produces res_exp = 0, underflow = 1, mantissa unshifted.
- Inputs are ignored outside IDLE.

Test Plan:
1. a=0x800000, b=0x400000, exp=0x80, out_ready=1 -> res_man=0x800000, res_exp=0x7F, sign=0, zero=0, underflow=0; out_valid from E3 (k=1), one cycle wide.
2. a=0x400000, b=0xC00000, exp=0x90 -> mag 0x800000, k=0, res_man=0x800000, res_exp=0x90, res_sign=1; out_valid from E2.
3. a=b=0xABCDEF, exp=0x55 -> res_zero=1, res_man=0, res_exp=0, res_sign=0; out_valid from E1.
4. a=0x800001, b=0x800000, exp=0x05 -> mag=1, four shifts to exp 1, then stop: res_man=0x000010, res_exp=0, underflow=1; out_valid from E6.
5. Case 1 with out_ready=0 for 5 cycles -> outputs held constant and in_ready=0 throughout; result accepted on the first edge with out_ready=1; in_ready=1 the following cycle.
6. Start case 4 (exp=0x20), assert rst for one cycle at E3 -> state IDLE, all outputs 0, no out_valid. A new operation (case 2) then completes correctly.
